pipeline_enable_ctrl: RTL and testbench
=======================================

# pipeline_enable_ctrl

Drives the write-enable and flush controls for the pipelined ARM datapath's IF/ID/EX/MEM/WB pipeline register banks. Each bank is built from enable-gated flip-flops, and this block is the source of those enables. It arbitrates three hazard sources: memory wait, taken branch, and load-use. It sequences multi-cycle stalls and flushes with a small FSM and keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- BRANCH_PENALTY, default 2: cycles flush_id stays asserted after a taken branch. Legal range is 1..15.
- CNT_W, default 16: width of the stall-cycle counter.

Ports:
- clk, in, 1: sole clock. Rising edge.
- reset, in, 1: asynchronous, active-low reset.
- mem_busy, in, 1: data memory not ready. Freezes the whole pipeline.
- branch_taken, in, 1: branch resolved taken in EX this cycle.
- load_use, in, 1: ID instruction depends on the load now in EX.
- en_if, en_id, en_ex, en_mem, en_wb, out, 1 each: pipeline register bank enables.
- flush_id, out, 1: replace the IF/ID register contents with a bubble.
- flush_ex, out, 1: replace the ID/EX register contents with a bubble.
- stall_cycles, out, CNT_W: saturating count of cycles with en_if=0.
- state_o, out, 2: current FSM state, for debug.

## Operation
- States: RUN=0, LOAD_BUBBLE=1, BR_FLUSH=2. The encoding value 3 is illegal; if reached, the block returns to RUN on the next edge.
- Outputs are combinational from the current state and inputs. State, the penalty counter (pc, 4 bits) and stall_cycles are registered.
- Input priority in every state: mem_busy > branch_taken > load_use.
- mem_busy=1, any state:
  - All five en_* are 0; flush_id and flush_ex are 0.
  - State and pc hold.
- branch_taken=1 with mem_busy=0, any state:
  - All en_* are 1; flush_id=1, flush_ex=1.
  - If BRANCH_PENALTY>1: next state BR_FLUSH, pc=BRANCH_PENALTY-1.
  - If BRANCH_PENALTY=1: next state RUN.
  - A branch taken during BR_FLUSH restarts pc.
- load_use=1 with no higher-priority input, in RUN only:
  - en_if=0, en_id=0, flush_ex=1; en_ex, en_mem, en_wb are 1.
  - Next state LOAD_BUBBLE.
- load_use in LOAD_BUBBLE or BR_FLUSH is ignored. The bubble already resolves the hazard, and a flushed ID cannot create one.
- RUN with no inputs asserted: all en_*=1, no flush.
- LOAD_BUBBLE with no inputs asserted: all en_*=1, no flush; next state RUN.
- BR_FLUSH with no inputs asserted:
  - All en_*=1, flush_id=1, flush_ex=0.
  - pc decrements; when pc==1 at the edge, next state is RUN.
- stall_cycles increments on each edge where en_if=0, and saturates at 2^CNT_W-1.

## Timing
- While reset is low: state=RUN, pc=0, stall_cycles=0. All en_*=0 and flush_*=0, forced combinationally.
- First edge after reset release: RUN outputs, meaning all en_*=1.
- Input-to-output latency is 0 cycles (combinational path). State effects appear after 1 edge.
- Load-use costs exactly 1 stall cycle plus 1 bubble.
- A taken branch asserts flush_id for BRANCH_PENALTY consecutive non-frozen cycles. mem_busy cycles stretch that window without consuming it.
- Simultaneous branch_taken and load_use: the branch wins and no stall occurs.
- Reset asserted mid-flush or mid-stall: the block immediately shows the reset values; nothing resumes after release.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - typedef enum logic [1:0] pipe_state_t {RUN, LOAD_BUBBLE, BR_FLUSH}.
  - The localparam PC_W=4.
- One sub-module, sat_counter, with parameter W, inputs clk, reset (active-low async) and inc, and output count. It implements stall_cycles.
- The FSM and output decode live in pipeline_enable_ctrl itself.

## Test plan
- Reset held low for 3 cycles, then released, with no inputs: all en_*=0 and stall_cycles=0 during reset; all en_*=1 and state_o=0 on the first post-release cycle.
- load_use pulsed 1 cycle in RUN: that cycle shows en_if=en_id=0, flush_ex=1; the next cycle shows state_o=1 with all enables 1; stall_cycles=1.
- BRANCH_PENALTY=3 with a branch_taken pulse: flush_id high for 3 cycles, flush_ex high on the first cycle only; state_o sequence 0→2→2→0.
- mem_busy held 4 cycles in the middle of a BR_FLUSH: all en_*=0 for 4 cycles, then flush_id resumes for the remaining cycles; stall_cycles increases by 4.
- branch_taken and load_use asserted together in RUN: en_if=1, flush_id=flush_ex=1, and no LOAD_BUBBLE follows.
- CNT_W=3 with mem_busy held 10 cycles: stall_cycles saturates at 7.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline enable/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        LOAD_BUBBLE = 2'd1,
        BR_FLUSH    = 2'd2
    } pipe_state_t;

    localparam int PC_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; used to count cycles in which instruction fetch is frozen.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count up on inc, sticking at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipeline_enable_ctrl.sv
// Pipeline register enable/flush controller: arbitrates memory wait, taken
// branch and load-use hazards, and counts fetch-stall cycles.
module pipeline_enable_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BRANCH_PENALTY = 2,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_busy,
    input  logic             branch_taken,
    input  logic             load_use,
    output logic             en_if,
    output logic             en_id,
    output logic             en_ex,
    output logic             en_mem,
    output logic             en_wb,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       state_o
);

    localparam logic [PC_W-1:0] PC_LOAD     = PC_W'(BRANCH_PENALTY - 1);
    localparam bit              MULTI_FLUSH = (BRANCH_PENALTY > 1);

    pipe_state_t     state_r;
    pipe_state_t     state_nxt_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_nxt_s;
    // Enable vector ordered {if, id, ex, mem, wb}
    logic [4:0]      en_vec_s;
    logic            flush_id_s;
    logic            flush_ex_s;
    logic            stall_inc_s;

    // Next-state and output decode, priority mem_busy > branch_taken > load_use
    always_comb begin
        en_vec_s    = 5'b11111;
        flush_id_s  = 1'b0;
        flush_ex_s  = 1'b0;
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        if (!reset) begin
            en_vec_s    = 5'b00000;
            state_nxt_s = RUN;
            pc_nxt_s    = {PC_W{1'b0}};
        end else if (mem_busy) begin
            en_vec_s = 5'b00000;
        end else if (branch_taken) begin
            flush_id_s = 1'b1;
            flush_ex_s = 1'b1;
            if (MULTI_FLUSH) begin
                state_nxt_s = BR_FLUSH;
                pc_nxt_s    = PC_LOAD;
            end else begin
                state_nxt_s = RUN;
                pc_nxt_s    = {PC_W{1'b0}};
            end
        end else begin
            case (state_r)
                RUN: begin
                    if (load_use) begin
                        en_vec_s    = 5'b00111;
                        flush_ex_s  = 1'b1;
                        state_nxt_s = LOAD_BUBBLE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                LOAD_BUBBLE: begin
                    state_nxt_s = RUN;
                end
                BR_FLUSH: begin
                    flush_id_s = 1'b1;
                    if (pc_r <= PC_W'(1)) begin
                        state_nxt_s = RUN;
                        pc_nxt_s    = {PC_W{1'b0}};
                    end else begin
                        pc_nxt_s = pc_r - PC_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                    pc_nxt_s    = {PC_W{1'b0}};
                end
            endcase
        end
    end

    // State and penalty counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= RUN;
            pc_r    <= {PC_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    assign stall_inc_s = ~en_vec_s[4];

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc_s),
        .count (stall_cycles)
    );

    assign en_if    = en_vec_s[4];
    assign en_id    = en_vec_s[3];
    assign en_ex    = en_vec_s[2];
    assign en_mem   = en_vec_s[1];
    assign en_wb    = en_vec_s[0];
    assign flush_id = flush_id_s;
    assign flush_ex = flush_ex_s;
    assign state_o  = state_r;

endmodule

// File: tb/tb_pipeline_enable_ctrl.sv
// Self-checking bench for pipeline_enable_ctrl: directed scenarios plus a
// randomized run against a behavioural hazard model.
module tb_pipeline_enable_ctrl;

    localparam int BP = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mb = 1'b0;
    logic bt = 1'b0;
    logic lu = 1'b0;

    logic a_if, a_id, a_ex, a_mem, a_wb, a_fid, a_fex;
    logic [15:0] a_stall;
    logic [1:0]  a_state;
    logic b_if, b_id, b_ex, b_mem, b_wb, b_fid, b_fex;
    logic [2:0]  b_stall;
    logic [1:0]  b_state;

    int errors = 0;
    int checks = 0;

    // Model state: remaining flush cycles after the current one, pending bubble, stall count
    int m_flush_left = 0;
    bit m_bubble = 1'b0;
    int m_stall = 0;
    logic [4:0] exp_en;
    logic exp_fid, exp_fex;
    logic [1:0] exp_state;
    logic [15:0] exp_stall;
    logic [2:0] exp_sat;

    always #5 clk = ~clk;

    pipeline_enable_ctrl #(.BRANCH_PENALTY(BP), .CNT_W(16)) dut (
        .clk(clk), .reset(rst), .mem_busy(mb), .branch_taken(bt), .load_use(lu),
        .en_if(a_if), .en_id(a_id), .en_ex(a_ex), .en_mem(a_mem), .en_wb(a_wb),
        .flush_id(a_fid), .flush_ex(a_fex), .stall_cycles(a_stall), .state_o(a_state)
    );

    pipeline_enable_ctrl #(.BRANCH_PENALTY(BP), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(rst), .mem_busy(mb), .branch_taken(bt), .load_use(lu),
        .en_if(b_if), .en_id(b_id), .en_ex(b_ex), .en_mem(b_mem), .en_wb(b_wb),
        .flush_id(b_fid), .flush_ex(b_fex), .stall_cycles(b_stall), .state_o(b_state)
    );

    wire [4:0] a_en = {a_if, a_id, a_ex, a_mem, a_wb};
    wire [4:0] b_en = {b_if, b_id, b_ex, b_mem, b_wb};

    // Apply inputs, move to the falling edge and compute what the outputs must be
    task automatic drive(input logic m, input logic b, input logic l);
        mb = m; bt = b; lu = l;
        @(negedge clk);
        exp_en = 5'b11111; exp_fid = 1'b0; exp_fex = 1'b0;
        if (!rst) begin
            m_flush_left = 0; m_bubble = 1'b0; m_stall = 0;
            exp_en = 5'b00000; exp_state = 2'd0;
        end else begin
            exp_state = (m_flush_left > 0) ? 2'd2 : (m_bubble ? 2'd1 : 2'd0);
            if (mb) exp_en = 5'b00000;
            else if (bt) begin exp_fid = 1'b1; exp_fex = 1'b1; end
            else if (m_flush_left > 0) exp_fid = 1'b1;
            else if (m_bubble) exp_en = 5'b11111;
            else if (lu) begin exp_en = 5'b00111; exp_fex = 1'b1; end
            else exp_en = 5'b11111;
        end
        exp_stall = 16'(m_stall);
        exp_sat = (m_stall > 7) ? 3'd7 : 3'(m_stall);
    endtask

    // Take the rising edge and advance the model
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            if (!exp_en[4]) m_stall++;
            if (mb) m_stall = m_stall;
            else if (bt) begin m_flush_left = BP - 1; m_bubble = 1'b0; end
            else if (m_flush_left > 0) m_flush_left--;
            else if (m_bubble) m_bubble = 1'b0;
            else if (lu) m_bubble = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            checks++;
            if (a_en !== 5'b00000 || a_fid !== 1'b0 || a_fex !== 1'b0 || a_stall !== 16'd0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got en=%b fid=%b fex=%b stall=%0d want en=00000 fid=0 fex=0 stall=0",
                         i, a_en, a_fid, a_fex, a_stall);
            end
            advance();
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (a_en !== 5'b11111 || a_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_release got en=%b state=%0d want en=11111 state=0", a_en, a_state);
        end
        advance();
    endtask

    task automatic test_load_use();
        logic [15:0] s0;
        s0 = a_stall;
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (a_en !== 5'b00111 || a_fex !== 1'b1 || a_fid !== 1'b0) begin
            errors++;
            $display("FAIL load_use_stall got en=%b fid=%b fex=%b want en=00111 fid=0 fex=1", a_en, a_fid, a_fex);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (a_state !== 2'd1 || a_en !== 5'b11111 || a_stall !== s0 + 16'd1) begin
            errors++;
            $display("FAIL load_use_bubble got state=%0d en=%b stall=%0d want state=1 en=11111 stall=%0d",
                     a_state, a_en, a_stall, s0 + 16'd1);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (a_state !== 2'd0) begin
            errors++;
            $display("FAIL load_use_return got state=%0d want 0", a_state);
        end
        advance();
    endtask

    task automatic test_branch();
        logic [1:0] want_st [4] = '{2'd0, 2'd2, 2'd2, 2'd0};
        logic       want_fid[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic       want_fex[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i == 0) ? 1'b1 : 1'b0, 1'b0);
            checks++;
            if (a_state !== want_st[i] || a_fid !== want_fid[i] || a_fex !== want_fex[i] || a_en !== 5'b11111) begin
                errors++;
                $display("FAIL branch_seq cyc=%0d got state=%0d fid=%b fex=%b en=%b want state=%0d fid=%b fex=%b en=11111",
                         i, a_state, a_fid, a_fex, a_en, want_st[i], want_fid[i], want_fex[i]);
            end
            advance();
        end
    endtask

    task automatic test_busy_in_flush();
        logic [15:0] s0;
        drive(1'b0, 1'b1, 1'b0);
        advance();
        drive(1'b0, 1'b0, 1'b0);
        advance();
        s0 = a_stall;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            checks++;
            if (a_en !== 5'b00000 || a_fid !== 1'b0 || a_state !== 2'd2) begin
                errors++;
                $display("FAIL busy_freeze cyc=%0d got en=%b fid=%b state=%0d want en=00000 fid=0 state=2",
                         i, a_en, a_fid, a_state);
            end
            advance();
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (a_fid !== 1'b1 || a_state !== 2'd2 || a_stall !== s0 + 16'd4) begin
            errors++;
            $display("FAIL busy_resume got fid=%b state=%0d stall=%0d want fid=1 state=2 stall=%0d",
                     a_fid, a_state, a_stall, s0 + 16'd4);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (a_fid !== 1'b0 || a_state !== 2'd0) begin
            errors++;
            $display("FAIL busy_end got fid=%b state=%0d want fid=0 state=0", a_fid, a_state);
        end
        advance();
    endtask

    task automatic test_branch_and_load();
        drive(1'b0, 1'b1, 1'b1);
        checks++;
        if (a_if !== 1'b1 || a_id !== 1'b1 || a_fid !== 1'b1 || a_fex !== 1'b1) begin
            errors++;
            $display("FAIL br_ld_same got en_if=%b en_id=%b fid=%b fex=%b want 1 1 1 1", a_if, a_id, a_fid, a_fex);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (a_state !== 2'd2 || a_en !== 5'b11111) begin
            errors++;
            $display("FAIL br_ld_next got state=%0d en=%b want state=2 en=11111", a_state, a_en);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0);
        advance();
    endtask

    task automatic test_reset_mid_flush();
        drive(1'b0, 1'b1, 1'b0);
        advance();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (a_en !== 5'b00000 || a_fid !== 1'b0 || a_state !== 2'd0 || a_stall !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid got en=%b fid=%b state=%0d stall=%0d want en=00000 fid=0 state=0 stall=0",
                     a_en, a_fid, a_state, a_stall);
        end
        advance();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (a_en !== 5'b11111 || a_fid !== 1'b0 || a_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_no_resume got en=%b fid=%b state=%0d want en=11111 fid=0 state=0", a_en, a_fid, a_state);
        end
        advance();
    endtask

    task automatic test_saturation();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        advance();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            advance();
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (b_stall !== 3'd7 || a_stall !== 16'd10) begin
            errors++;
            $display("FAIL saturate got narrow=%0d wide=%0d want narrow=7 wide=10", b_stall, a_stall);
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
            checks++;
            if (a_en !== exp_en || a_fid !== exp_fid || a_fex !== exp_fex || a_state !== exp_state ||
                a_stall !== exp_stall || b_stall !== exp_sat || b_en !== exp_en) begin
                errors++;
                $display("FAIL random cyc=%0d in=%b%b%b%b got en=%b fid=%b fex=%b st=%0d stall=%0d sat=%0d want en=%b fid=%b fex=%b st=%0d stall=%0d sat=%0d",
                         i, rst, mb, bt, lu, a_en, a_fid, a_fex, a_state, a_stall, b_stall,
                         exp_en, exp_fid, exp_fex, exp_state, exp_stall, exp_sat);
            end
            advance();
        end
        rst = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_busy_in_flush();
        test_branch_and_load();
        test_reset_mid_flush();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
